// File: rtl/id_hazard_unit.sv
// ID-stage hazard controller: load-use stalls, branch wait/squash
// sequencing and a saturating bubble counter.
module id_hazard_unit #(
  parameter int BR_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [5:0]       Opcode_ID,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             MemRead_EX,
  input  logic [4:0]       Rt_EX,
  input  logic             Branch_Taken_MEM,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_Flush,
  output logic             ID_Control_NOP,
  output logic             ID_EX_Flush,
  output logic [CNT_W-1:0] Stall_Count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JUMP  = 6'b000010;

  localparam logic [2:0] WAIT_INIT = 3'(BR_LAT - 1);

  typedef enum logic {
    RUN,
    BR_WAIT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       wait_q;
  logic [2:0]       wait_d;
  logic [CNT_W-1:0] cnt_q;

  logic is_rtype;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_jump;
  logic rs_used;
  logic rt_used;
  logic rs_hit;
  logic rt_hit;
  logic lu;
  logic bubble;

  assign is_rtype = (Opcode_ID == OP_RTYPE);
  assign is_lw    = (Opcode_ID == OP_LW);
  assign is_sw    = (Opcode_ID == OP_SW);
  assign is_beq   = (Opcode_ID == OP_BEQ);
  assign is_jump  = (Opcode_ID == OP_JUMP);

  assign rs_used = is_rtype | is_lw | is_sw | is_beq;
  assign rt_used = is_rtype | is_sw | is_beq;

  assign rs_hit = rs_used && (Rs_ID == Rt_EX);
  assign rt_hit = rt_used && (Rt_ID == Rt_EX);

  // r0 is hardwired, so a load "into" it never creates a dependency
  assign lu = MemRead_EX && (Rt_EX != 5'd0) && (rs_hit || rt_hit);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RUN;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_Flush    = 1'b0;
    bubble      = 1'b0;
    if (!Reset_n) begin
      state_d     = RUN;
      wait_d      = 3'd0;
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      bubble      = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            bubble      = 1'b1;
          end else if (is_jump) begin
            IF_Flush = 1'b1;
          end else if (is_beq) begin
            state_d = BR_WAIT;
            wait_d  = WAIT_INIT;
          end
        end
        BR_WAIT: begin
          if (wait_q != 3'd0) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            bubble      = 1'b1;
            wait_d      = wait_q - 3'd1;
          end else begin
            state_d = RUN;
            // taken: squash both the wrong-path fetch and the held ID slot
            if (Branch_Taken_MEM) begin
              IF_Flush = 1'b1;
              bubble   = 1'b1;
            end
          end
        end
        default: begin
          state_d = RUN;
          wait_d  = 3'd0;
        end
      endcase
    end
  end

  assign ID_Control_NOP = bubble;
  assign ID_EX_Flush    = bubble;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (ID_EX_Flush && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign Stall_Count = cnt_q;

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed bench for id_hazard_unit with a cycle-indexed reference model
// and per-cycle output comparison.
module tb_id_hazard_unit;

  localparam int BR_LAT = 2;
  localparam int CNT_W  = 16;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100;
  localparam logic [5:0] JP = 6'b000010;

  logic             clk;
  logic             rst_n;
  logic [5:0]       op;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             mr;
  logic [4:0]       rte;
  logic             tk;
  logic             pc_w;
  logic             ifid_w;
  logic             if_fl;
  logic             nop;
  logic             idex_fl;
  logic [CNT_W-1:0] scnt;

  int tests;
  int fails;
  int cyc;
  int resolve;
  longint mcnt;
  bit chk_en;

  id_hazard_unit #(.BR_LAT(BR_LAT), .CNT_W(CNT_W)) dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .Opcode_ID(op),
    .Rs_ID(rs),
    .Rt_ID(rt),
    .MemRead_EX(mr),
    .Rt_EX(rte),
    .Branch_Taken_MEM(tk),
    .PCWrite(pc_w),
    .IF_ID_Write(ifid_w),
    .IF_Flush(if_fl),
    .ID_Control_NOP(nop),
    .ID_EX_Flush(idex_fl),
    .Stall_Count(scnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic bit lu_m();
    bit rs_src;
    bit rt_src;
    rs_src = (op == RT) || (op == LW) || (op == SW) || (op == BQ);
    rt_src = (op == RT) || (op == SW) || (op == BQ);
    return mr && rte != 0 &&
           ((rs_src && rs == rte) || (rt_src && rt == rte));
  endfunction

  // {pc, ifid, if_flush, nop, idex_flush}
  function automatic logic [4:0] expect_out();
    if (!rst_n) return 5'b00011;
    if (resolve >= 0 && cyc < resolve) return 5'b00011;
    if (resolve >= 0 && cyc == resolve)
      return tk ? 5'b11111 : 5'b11000;
    if (lu_m()) return 5'b00011;
    if (op == JP) return 5'b11100;
    return 5'b11000;
  endfunction

  always @(posedge clk) begin
    logic [4:0] e;
    if (!rst_n) begin
      resolve = -1;
      mcnt = 0;
    end else begin
      e = expect_out();
      if (e[0] && mcnt < CNT_MAX) mcnt++;
      if (resolve >= 0 && cyc == resolve) resolve = -1;
      else if (resolve < 0 && !lu_m() && op == BQ)
        resolve = cyc + BR_LAT;
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (chk_en) begin
      e = expect_out();
      chk("m_pcwrite", pc_w, e[4]);
      chk("m_ifid_wr", ifid_w, e[3]);
      chk("m_if_flush", if_fl, e[2]);
      chk("m_nop", nop, e[1]);
      chk("m_idex_fl", idex_fl, e[0]);
      chk("m_stall_cnt", scnt, rst_n ? mcnt : 0);
    end
  end

  task automatic step(input logic r, input logic [5:0] o,
                      input logic [4:0] s, input logic [4:0] t,
                      input logic m, input logic [4:0] te,
                      input logic b);
    @(posedge clk);
    #1;
    rst_n = r; op = o; rs = s; rt = t;
    mr = m; rte = te; tk = b;
    #3;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    resolve = -1; mcnt = 0;
    rst_n = 1'b0; op = RT; rs = 0; rt = 0;
    mr = 0; rte = 0; tk = 0;
    chk_en = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step(0, 6'($urandom), 5'($urandom), 5'($urandom),
           1'($urandom), 5'($urandom), 1'($urandom));
      chk("rst_nop", nop, 1);
      chk("rst_flush", idex_fl, 1);
      chk("rst_pc", pc_w, 0);
      chk("rst_ifid", ifid_w, 0);
      chk("rst_cnt", scnt, 0);
    end

    step(1, RT, 1, 2, 0, 0, 0);
    chk("rel_pc", pc_w, 1);
    chk("rel_ifid", ifid_w, 1);

    step(1, RT, 1, 5, 1, 5, 0);
    chk("lu_pc", pc_w, 0);
    chk("lu_nop", nop, 1);
    step(1, RT, 1, 5, 0, 5, 0);
    chk("lu_done_pc", pc_w, 1);
    chk("lu_cnt", scnt, 1);

    step(1, RT, 0, 0, 1, 0, 0);
    chk("r0_pc", pc_w, 1);
    chk("r0_nop", nop, 0);

    step(1, SW, 1, 7, 1, 7, 0);
    chk("sw_pc", pc_w, 0);
    step(1, SW, 1, 7, 0, 7, 0);
    chk("sw_cnt", scnt, 2);
    step(1, LW, 3, 7, 1, 7, 0);
    chk("lw_rt_pc", pc_w, 1);
    chk("lw_rt_nop", nop, 0);

    step(1, BQ, 1, 2, 0, 0, 1);
    chk("bnt0_pc", pc_w, 1);
    chk("bnt0_iff", if_fl, 0);
    step(1, RT, 1, 2, 0, 0, 0);
    chk("bnt1_pc", pc_w, 0);
    chk("bnt1_nop", nop, 1);
    step(1, RT, 1, 2, 0, 0, 0);
    chk("bnt2_pc", pc_w, 1);
    chk("bnt2_nop", nop, 0);
    chk("bnt2_cnt", scnt, 3);

    step(1, BQ, 1, 2, 0, 0, 0);
    step(1, RT, 1, 2, 0, 0, 0);
    chk("bt1_nop", nop, 1);
    step(1, RT, 1, 2, 0, 0, 1);
    chk("bt2_iff", if_fl, 1);
    chk("bt2_nop", nop, 1);
    chk("bt2_pc", pc_w, 1);
    chk("bt2_cnt", scnt, 4);
    step(1, RT, 1, 2, 0, 0, 1);
    chk("bt3_iff", if_fl, 0);
    chk("bt3_nop", nop, 0);
    chk("bt3_cnt", scnt, 5);

    step(1, JP, 0, 0, 0, 0, 0);
    chk("jp_iff", if_fl, 1);
    chk("jp_pc", pc_w, 1);
    chk("jp_nop", nop, 0);
    step(1, RT, 1, 2, 0, 0, 0);
    chk("jp_after_iff", if_fl, 0);
    chk("jp_cnt", scnt, 5);

    step(1, BQ, 4, 2, 1, 4, 0);
    chk("lubq_pc", pc_w, 0);
    step(1, BQ, 4, 2, 0, 4, 0);
    chk("lubq_adv_pc", pc_w, 1);
    chk("lubq_cnt", scnt, 6);
    step(1, RT, 1, 2, 0, 0, 0);
    chk("lubq_bub", pc_w, 0);
    step(1, RT, 1, 2, 0, 0, 0);
    chk("lubq_res_pc", pc_w, 1);
    chk("lubq_res_cnt", scnt, 7);

    step(1, BQ, 1, 2, 0, 0, 0);
    step(0, RT, 1, 2, 0, 0, 0);
    chk("rbw_nop", nop, 1);
    chk("rbw_pc", pc_w, 0);
    chk("rbw_cnt", scnt, 0);
    step(1, RT, 1, 2, 0, 0, 1);
    chk("rbw_rel_pc", pc_w, 1);
    chk("rbw_rel_iff", if_fl, 0);
    chk("rbw_rel_nop", nop, 0);
    step(1, RT, 1, 2, 0, 0, 1);
    chk("rbw_run_iff", if_fl, 0);
    chk("rbw_run_cnt", scnt, 0);

    step(1, RT, 0, 0, 0, 0, 0);
    step(1, RT, 0, 0, 0, 0, 0);
    @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_hazard_unit.md
# id_hazard_unit

- Pipeline hazard controller sitting directly upstream of the ID-stage control decoder.
- Detects load-use hazards and sequences branch/jump squashes.
- Drives the decoder's NOP-force input, the PC and IF/ID write enables, the IF/ID flush and the ID/EX flush.
- Holds a small branch-wait FSM and a saturating stall counter for performance monitoring.

## Interface
Parameters:
- BR_LAT, 2, cycles from a BEQ leaving ID until its outcome is valid on Branch_Taken_MEM; legal range 1..7.
- CNT_W, 16, width of Stall_Count.

Ports:
- Clk  in  1  pipeline clock. One clock domain.
- Reset_n  in  1  asynchronous, active-low reset.
- Opcode_ID  in  6  opcode [31:26] of the instruction in ID. Encodings: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, JUMP 000010, NOP 100000.
- Rs_ID  in  5  rs field of the ID instruction.
- Rt_ID  in  5  rt field of the ID instruction.
- MemRead_EX  in  1  the instruction in EX is a load.
- Rt_EX  in  5  destination register of that load.
- Branch_Taken_MEM  in  1  BEQ outcome. Sampled only in the resolve cycle.
- PCWrite  out  1  PC register enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_Flush  out  1  clears IF/ID at the next edge.
- ID_Control_NOP  out  1  forces NOP control signals in the decoder.
- ID_EX_Flush  out  1  clears ID/EX at the next edge. Always asserted together with ID_Control_NOP, because the decoder does not suppress BEQ.
- Stall_Count  out  CNT_W  count of bubble cycles, saturating.

## Operation
Source-use rule:
- Rs_ID is a source for RTYPE, LW, SW and BEQ.
- Rt_ID is a source for RTYPE, SW and BEQ.
- Register 0 never causes a hazard.

Load-use condition (LU): MemRead_EX && Rt_EX != 0 && Rt_EX matches a source register of the ID instruction.

FSM state RUN:
- If LU: PCWrite=0, IF_ID_Write=0, ID_Control_NOP=1, ID_EX_Flush=1. Stay in RUN. The ID instruction is held and retried.
- Else if Opcode_ID==JUMP: IF_Flush=1 and all other outputs are normal. The wrong-path fetch is squashed while the PC takes the jump target.
- Else if Opcode_ID==BEQ: outputs are normal, so the BEQ advances to EX. Next state is BR_WAIT with wait_cnt=BR_LAT-1.
- Otherwise: PCWrite=1, IF_ID_Write=1, all flush and NOP outputs 0.

FSM state BR_WAIT:
- wait_cnt != 0: PCWrite=0, IF_ID_Write=0, ID_Control_NOP=1, ID_EX_Flush=1. Decrement wait_cnt.
- wait_cnt == 0 (resolve cycle), branch taken: PCWrite=1, IF_Flush=1, ID_Control_NOP=1, ID_EX_Flush=1. Return to RUN.
- wait_cnt == 0 (resolve cycle), branch not taken: normal outputs. The held instruction proceeds. Return to RUN.
- LU, JUMP and BEQ decoding are ignored in BR_WAIT. A not-taken resolve cycle re-evaluates nothing; the held instruction was already hazard-checked.

Stall_Count:
- Increments by 1 on each cycle with ID_EX_Flush=1 while out of reset.
- Saturates at 2^CNT_W-1.

## Timing
- All outputs are combinational from the state and the current inputs. State, wait_cnt and Stall_Count are registered on the rising edge of Clk.
- While Reset_n=0: state=RUN, wait_cnt=0, Stall_Count=0, PCWrite=0, IF_ID_Write=0, IF_Flush=0, ID_Control_NOP=1, ID_EX_Flush=1.
- Stall_Count does not count reset cycles.
- Reset asserted mid-BR_WAIT aborts the wait immediately. After release the block is in RUN.
- Load-use stall costs exactly 1 cycle. The bubble clears MemRead_EX, so LU drops on the next cycle.
- BEQ costs BR_LAT-1 bubbles if not taken and BR_LAT bubbles if taken.
- JUMP costs 1 squashed fetch and no FSM state.
- LU together with BEQ in ID: LU wins. The BEQ is held, and BR_WAIT is entered only in the cycle the BEQ actually advances.
- Branch_Taken_MEM outside the resolve cycle: no effect.

## Test plan
- Reset: hold Reset_n=0 for 3 cycles with random inputs -> ID_Control_NOP=1, ID_EX_Flush=1, PCWrite=0, IF_ID_Write=0, Stall_Count=0. After release with an RTYPE in ID -> PCWrite=1, IF_ID_Write=1.
- Load-use: MemRead_EX=1, Rt_EX=5, RTYPE with Rt_ID=5 -> exactly 1 cycle of PCWrite=0/NOP=1, Stall_Count=1. Repeat with Rt_EX=0 -> no stall.
- SW rt hazard vs LW rt non-hazard: Rt_EX=7; SW with Rt_ID=7 stalls; LW with Rt_ID=7, Rs_ID=3 does not.
- BEQ not taken, BR_LAT=2: BEQ at cycle t -> bubble at t+1; at t+2 Branch_Taken_MEM=0 gives normal outputs; Stall_Count +1.
- BEQ taken, BR_LAT=2 -> bubble at t+1. At t+2: IF_Flush=1, NOP=1, PCWrite=1. Stall_Count +2. Back in RUN at t+3.
- JUMP in ID -> IF_Flush=1 for 1 cycle, no stall. Also: pulse Reset_n low during BR_WAIT -> RUN after release; Branch_Taken_MEM then ignored.
